// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation codes, FSM state encoding, iteration count and op decode helpers.
package ex_muldiv_ctrl_pkg;

    localparam int MdIter = 32;

    typedef enum logic [2:0] {
        MD_MUL_W   = 3'd0,
        MD_MULH_W  = 3'd1,
        MD_MULH_WU = 3'd2,
        MD_DIV_W   = 3'd3,
        MD_MOD_W   = 3'd4,
        MD_DIV_WU  = 3'd5,
        MD_MOD_WU  = 3'd6,
        MD_RSVD    = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return (op == MD_DIV_W) || (op == MD_MOD_W) ||
               (op == MD_DIV_WU) || (op == MD_MOD_WU);
    endfunction

    function automatic logic op_is_rem(md_op_e op);
        return (op == MD_MOD_W) || (op == MD_MOD_WU);
    endfunction

    function automatic logic op_is_hi(md_op_e op);
        return (op == MD_MULH_W) || (op == MD_MULH_WU);
    endfunction

    // Reserved code 7 runs as MUL.W, so it is signed too.
    function automatic logic op_is_signed(md_op_e op);
        return !((op == MD_MULH_WU) || (op == MD_DIV_WU) ||
                 (op == MD_MOD_WU));
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_md_iter_dp.sv
// Radix-2 iteration datapath: 2W-bit accumulator plus operand register.
// Ports: clr_i/load_i/step_i/div_i control, lo_i/opnd_i load values, acc_o.
module md_iter_dp
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           div_i,
    input  logic [W-1:0]   lo_i,
    input  logic [W-1:0]   opnd_i,
    output logic [2*W-1:0] acc_o
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opnd_q;
    logic [W:0]     madd;
    logic [2*W:0]   dsh;
    logic [W+1:0]   diff;

    // Multiply: acc = {partial product, multiplier}, shifted right.
    // Divide:   acc = {remainder, quotient}, shifted left.
    always_comb begin
        madd  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
        dsh   = {acc_q, 1'b0};
        diff  = {1'b0, dsh[2*W:W]} - {2'b00, opnd_q};
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{W{1'b0}}, lo_i};
        end else if (step_i) begin
            if (div_i) begin
                // Top bit of diff set means the trial subtract borrowed.
                acc_d = diff[W+1] ? dsh[2*W-1:0]
                                  : {diff[W-1:0], dsh[W-1:1], 1'b1};
            end else begin
                acc_d = acc_q[0] ? {madd, acc_q[W-1:1]}
                                 : {1'b0, acc_q[2*W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) opnd_q <= opnd_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MUL/MULH/DIV/MOD sequencer for EX; holds result until ack.
// Ports: md_start_i/md_op_i/md_src1_i/md_src2_i launch, md_ack_i release,
// md_flush_i abort, md_busy_o/md_done_o/md_result_o status and result.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         md_start_i,
    input  logic [2:0]   md_op_i,
    input  logic [W-1:0] md_src1_i,
    input  logic [W-1:0] md_src2_i,
    input  logic         md_ack_i,
    input  logic         md_flush_i,
    output logic         md_busy_o,
    output logic         md_done_o,
    output logic [W-1:0] md_result_o
);

    md_state_e      state_q;
    md_op_e         op_q, op_d;
    logic [4:0]     cnt_q;
    logic           sign1_q, sign2_q, dz_q;
    logic           sign1_d, sign2_d, dz_d, div_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   abs1, abs2;
    logic [2*W-1:0] acc, prod;
    logic [W-1:0]   quot, rem_mag, rem;
    logic           neg, load, step;

    // Launch-side decode of the incoming operation.
    always_comb begin
        op_d    = md_op_e'(md_op_i);
        div_d   = op_is_div(op_d);
        sign1_d = op_is_signed(op_d) & md_src1_i[W-1];
        sign2_d = op_is_signed(op_d) & md_src2_i[W-1];
        abs1    = sign1_d ? -md_src1_i : md_src1_i;
        abs2    = sign2_d ? -md_src2_i : md_src2_i;
        dz_d    = div_d && (md_src2_i == '0);
    end

    assign load = (state_q == S_IDLE) && md_start_i && !md_flush_i;
    assign step = (state_q == S_CALC) && !md_flush_i;

    md_iter_dp #(.W(W)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (md_flush_i),
        .load_i (load),
        .step_i (step),
        .div_i  (op_is_div(op_q)),
        .lo_i   (div_d ? abs1 : abs2),
        .opnd_i (div_d ? abs2 : abs1),
        .acc_o  (acc)
    );

    // Sign correction and result select; on divide-by-zero the
    // accumulator still holds |dividend| in its low half.
    always_comb begin
        neg     = sign1_q ^ sign2_q;
        prod    = neg ? -acc : acc;
        quot    = dz_q ? '1 : (neg ? -acc[W-1:0] : acc[W-1:0]);
        rem_mag = dz_q ? acc[W-1:0] : acc[2*W-1:W];
        rem     = sign1_q ? -rem_mag : rem_mag;
        if (op_is_rem(op_q))      result_d = rem;
        else if (op_is_div(op_q)) result_d = quot;
        else if (op_is_hi(op_q))  result_d = prod[2*W-1:W];
        else                      result_d = prod[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= MD_MUL_W;
            cnt_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else if (md_flush_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (md_start_i) begin
                    op_q    <= op_d;
                    sign1_q <= sign1_d;
                    sign2_q <= sign2_d;
                    dz_q    <= dz_d;
                    cnt_q   <= '0;
                    state_q <= dz_d ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MdIter - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= result_d;
                    state_q  <= S_DONE;
                end
                S_DONE: if (md_ack_i) begin
                    result_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign md_busy_o   = (state_q != S_IDLE);
    assign md_done_o   = (state_q == S_DONE);
    assign md_result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed vector table, random ops vs model,
// and hand sequences for stall, flush and reset-in-flight.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_start_i = 1'b0;
    logic [2:0]  md_op_i = '0;
    logic [31:0] md_src1_i = '0;
    logic [31:0] md_src2_i = '0;
    logic        md_ack_i = 1'b0;
    logic        md_flush_i = 1'b0;
    logic        md_busy_o, md_done_o;
    logic [31:0] md_result_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_ctrl #(.W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_start_i  (md_start_i),
        .md_op_i     (md_op_i),
        .md_src1_i   (md_src1_i),
        .md_src2_i   (md_src2_i),
        .md_ack_i    (md_ack_i),
        .md_flush_i  (md_flush_i),
        .md_busy_o   (md_busy_o),
        .md_done_o   (md_done_o),
        .md_result_o (md_result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV / and % truncate toward zero.
    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, r;
        longint unsigned ua, ub, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin r = sa * sb; return r[63:32]; end
            3'd2: begin ur = ua * ub; return ur[63:32]; end
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = sa / sb; return r[31:0];
            end
            3'd4: begin
                if (b == 0) return a;
                r = sa % sb; return r[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                ur = ua / ub; return ur[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                ur = ua % ub; return ur[31:0];
            end
            default: begin r = sa * sb; return r[31:0]; end
        endcase
    endfunction

    // Launches one op from a negedge, scrambles operands after the
    // start edge, waits for done, checks latency/result, then acks.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input string name);
        int  n;
        int  lat;
        bit  seen;
        bit  dz;
        dz = (op >= 3'd3) && (op <= 3'd6) && (b == 0);
        md_start_i = 1'b1;
        md_op_i    = op;
        md_src1_i  = a;
        md_src2_i  = b;
        md_ack_i   = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                md_start_i = 1'b0;
                md_op_i    = 3'($urandom);
                md_src1_i  = $urandom;
                md_src2_i  = $urandom;
                check({name, " busy"}, {31'd0, md_busy_o}, 32'd1);
                check({name, " res0"}, md_result_o, 32'd0);
            end
            if (md_done_o) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
        end
        check({name, " seen"}, {31'd0, seen}, 32'd1);
        check({name, " lat"}, lat, dz ? 32'd2 : 32'd34);
        check({name, " res"}, md_result_o, exp);
        md_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        md_ack_i = 1'b0;
        check({name, " idle"}, {30'd0, md_busy_o, md_done_o}, 32'd0);
        check({name, " clr"}, md_result_o, 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        bit          ok;

        tbl[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        tbl[5]  = '{3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF};
        tbl[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tbl[9]  = '{3'd4, 32'd5, 32'd0, 32'd5};
        tbl[10] = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tbl[11] = '{3'd6, 32'd100, 32'd7, 32'd2};
        tbl[12] = '{3'd7, 32'd6, 32'd7, 32'd42};
        tbl[13] = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tbl[14] = '{3'd4, 32'd7, 32'hFFFF_FFFE, 32'd1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'd0, md_busy_o}, 32'd0);
        check("rst done", {31'd0, md_done_o}, 32'd0);
        check("rst res", md_result_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rnd%0d", i));
        end

        // Stall in DONE with start held: no relaunch, result stable.
        md_start_i = 1'b1;
        md_op_i    = 3'd3;
        md_src1_i  = 32'hFFFF_FFF9;
        md_src2_i  = 32'd2;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (md_done_o) ok = 1'b1;
        end
        check("stall seen", {31'd0, ok}, 32'd1);
        held = md_result_o;
        check("stall res", held, 32'hFFFF_FFFD);
        md_op_i   = 3'd0;
        md_src1_i = 32'd3;
        md_src2_i = 32'd4;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall hold", {md_result_o[31:1], md_done_o & md_result_o[0]},
                  {held[31:1], held[0]});
            check("stall done", {31'd0, md_done_o}, 32'd1);
        end
        md_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        md_ack_i = 1'b0;
        check("stall idle", {31'd0, md_busy_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        md_start_i = 1'b0;
        check("relaunch busy", {31'd0, md_busy_o}, 32'd1);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (md_done_o) ok = 1'b1;
        end
        check("relaunch seen", {31'd0, ok}, 32'd1);
        check("relaunch res", md_result_o, 32'd12);
        md_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        md_ack_i = 1'b0;

        // Flush during CALC iteration 15.
        md_start_i = 1'b1;
        md_op_i    = 3'd0;
        md_src1_i  = 32'd9;
        md_src2_i  = 32'd9;
        @(posedge clk);
        @(negedge clk);
        md_start_i = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        md_flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        md_flush_i = 1'b0;
        check("flush idle", {30'd0, md_busy_o, md_done_o}, 32'd0);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (md_done_o || md_busy_o) ok = 1'b1;
        end
        check("flush quiet", {31'd0, ok}, 32'd0);

        // Reset while in FIX (after start edge plus 32 CALC edges).
        md_start_i = 1'b1;
        md_op_i    = 3'd3;
        md_src1_i  = 32'd100;
        md_src2_i  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        md_start_i = 1'b0;
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("fix busy", {31'd0, md_busy_o}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst idle", {30'd0, md_busy_o, md_done_o}, 32'd0);
        check("rst res0", md_result_o, 32'd0);
        ok = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (md_done_o) ok = 1'b1;
        end
        check("rst quiet", {31'd0, ok}, 32'd0);

        run_op(3'd0, 32'd3, 32'd4, 32'd12, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
